// File: rtl/j_i2s_dac_tx.sv
// Philips I2S master transmitter: derives SCK/WS from clk, double-buffers the
// left/right samples and shifts them MSB-first one SCK after each WS edge.
module j_i2s_dac_tx #(
    parameter int SCK_DIV = 4,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             enable,
    input  logic [WIDTH-1:0] snd_l,
    input  logic [WIDTH-1:0] snd_r,
    input  logic             snd_l_en,
    input  logic             snd_r_en,
    output logic             sckout,
    output logic             wsout,
    output logic             txd,
    output logic             sample_req,
    output logic             underrun
);

    localparam int FRAME = 2 * WIDTH;
    localparam int SW    = $clog2(FRAME);

    localparam logic [7:0]    DIV_LAST  = 8'(SCK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(FRAME - 1);
    localparam logic [SW-1:0] WS_FIRST  = SW'(WIDTH - 1);
    localparam logic [SW-1:0] WS_LAST   = SW'(FRAME - 2);

    logic [7:0]       div_cnt_q, div_cnt_d;
    logic             sck_q, sck_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic             ws_q, ws_d;
    logic             txd_q, txd_d;
    logic             req_q, req_d;
    logic             und_q, und_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;
    logic             pend_l_q, pend_l_d;
    logic             pend_r_q, pend_r_d;

    logic             fe;
    logic             pair_ready;
    logic             load;

    always_comb begin
        div_cnt_d  = div_cnt_q;
        sck_d      = sck_q;
        slot_d     = slot_q;
        ws_d       = ws_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        req_d      = 1'b0;
        und_d      = 1'b0;
        fe         = 1'b0;
        load       = 1'b0;
        pair_ready = pend_l_q && pend_r_q;

        if (enable) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = 8'd0;
                sck_d     = ~sck_q;
                fe        = sck_q;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end

            if (fe) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
                // Without a fresh pair, one extra rotation realigns the old frame
                if (slot_d == '0) begin
                    req_d = 1'b1;
                    if (pair_ready) begin
                        load    = 1'b1;
                        shift_d = {hold_l_q, hold_r_q};
                    end else begin
                        und_d   = 1'b1;
                        shift_d = {shift_q[FRAME-2:0], shift_q[FRAME-1]};
                    end
                end else begin
                    shift_d = {shift_q[FRAME-2:0], shift_q[FRAME-1]};
                end
                txd_d = shift_d[FRAME-1];
                ws_d  = (slot_d >= WS_FIRST) && (slot_d <= WS_LAST);
            end
        end else begin
            div_cnt_d = 8'd0;
            sck_d     = 1'b0;
            slot_d    = SLOT_LAST;
            ws_d      = 1'b0;
            txd_d     = 1'b0;
            shift_d   = '0;
        end

        // A strobe coinciding with the transfer still leaves its flag set
        hold_l_d = snd_l_en ? snd_l : hold_l_q;
        hold_r_d = snd_r_en ? snd_r : hold_r_q;
        pend_l_d = (pend_l_q && !load) || snd_l_en;
        pend_r_d = (pend_r_q && !load) || snd_r_en;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            div_cnt_q <= 8'd0;
            sck_q     <= 1'b0;
            slot_q    <= SLOT_LAST;
            ws_q      <= 1'b0;
            txd_q     <= 1'b0;
            req_q     <= 1'b0;
            und_q     <= 1'b0;
            shift_q   <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            pend_l_q  <= 1'b0;
            pend_r_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            slot_q    <= slot_d;
            ws_q      <= ws_d;
            txd_q     <= txd_d;
            req_q     <= req_d;
            und_q     <= und_d;
            shift_q   <= shift_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            pend_l_q  <= pend_l_d;
            pend_r_q  <= pend_r_d;
        end
    end

    assign sckout     = sck_q;
    assign wsout      = ws_q;
    assign txd        = txd_q;
    assign sample_req = req_q;
    assign underrun   = und_q;

endmodule
